// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : op codes, FSM states and op-class helper for alu_mc        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SLL    = 5'd1;
   localparam logic [4:0] ALU_SRA    = 5'd2;
   localparam logic [4:0] ALU_SUB    = 5'd3;
   localparam logic [4:0] ALU_XOR    = 5'd4;
   localparam logic [4:0] ALU_LINK   = 5'd5;
   localparam logic [4:0] ALU_PASS   = 5'd6;
   localparam logic [4:0] ALU_BGE    = 5'd7;
   localparam logic [4:0] ALU_BNE    = 5'd8;
   localparam logic [4:0] ALU_OR     = 5'd9;
   localparam logic [4:0] ALU_AND    = 5'd10;
   localparam logic [4:0] ALU_SRL    = 5'd11;
   localparam logic [4:0] ALU_SLT    = 5'd12;
   localparam logic [4:0] ALU_SLTU   = 5'd13;
   localparam logic [4:0] ALU_BEQ    = 5'd14;
   localparam logic [4:0] ALU_BLT    = 5'd15;
   localparam logic [4:0] ALU_BLTU   = 5'd16;
   localparam logic [4:0] ALU_BGEU   = 5'd17;
   localparam logic [4:0] ALU_MUL    = 5'd18;
   localparam logic [4:0] ALU_MULH   = 5'd19;
   localparam logic [4:0] ALU_MULHSU = 5'd20;
   localparam logic [4:0] ALU_MULHU  = 5'd21;
   localparam logic [4:0] ALU_DIV    = 5'd22;
   localparam logic [4:0] ALU_DIVU   = 5'd23;
   localparam logic [4:0] ALU_REM    = 5'd24;
   localparam logic [4:0] ALU_REMU   = 5'd25;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic logic is_md_op(input logic [4:0] op);
      return (op >= ALU_MUL) && (op <= ALU_REMU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_base.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_base : single-cycle combinational datapath for base ops 0-17     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_base
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      op,
   output logic [XLEN-1:0] res,
   output logic            zero
);

   localparam int SH_W = $clog2(XLEN);

   logic [SH_W-1:0] shamt;
   logic            lt_s;
   logic            lt_u;
   logic            eq;

   assign shamt = b[SH_W-1:0];
   assign lt_s  = $signed(a) < $signed(b);
   assign lt_u  = a < b;
   assign eq    = a == b;

   // Branch ops only drive the taken flag; their data result stays 0.
   always_comb begin
      res  = '0;
      zero = 1'b0;
      case (op)
         ALU_ADD:  res = a + b;
         ALU_SLL:  res = a << shamt;
         ALU_SRA:  res = $unsigned($signed(a) >>> shamt);
         ALU_SUB:  res = a - b;
         ALU_XOR:  res = a ^ b;
         ALU_LINK: begin
            res  = a + XLEN'(4);
            zero = 1'b1;
         end
         ALU_PASS: res = b;
         ALU_BGE:  zero = ~lt_s;
         ALU_BNE:  zero = ~eq;
         ALU_OR:   res = a | b;
         ALU_AND:  res = a & b;
         ALU_SRL:  res = a >> shamt;
         ALU_SLT:  res = {{(XLEN-1){1'b0}}, lt_s};
         ALU_SLTU: res = {{(XLEN-1){1'b0}}, lt_u};
         ALU_BEQ:  zero = eq;
         ALU_BLT:  zero = lt_s;
         ALU_BLTU: zero = lt_u;
         ALU_BGEU: zero = ~lt_u;
         default:  ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mc : multi-cycle ALU, base ops in 1 cycle, iterative RV32M ops   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_mc
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int OP_W  = 5,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [OP_W-1:0] alu_ctrl_i,
   input  logic            kill_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] data_o,
   output logic            zero_o,
   output logic            busy_o
);

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_nxt;
   logic [XLEN-1:0]   opa, opb, mag_b, acc_hi, acc_lo, data_q;
   logic [OP_W-1:0]   op_q;
   logic [CNT_W-1:0]  cnt;
   logic              neg_res, zero_q, accept;
   logic [XLEN-1:0]   base_res;
   logic              base_zero;

   assign accept = valid_i && (state == IDLE) && !kill_i;

   alu_base #(.XLEN(XLEN)) u_base (
      .a    (op1_i),
      .b    (op2_i),
      .op   (alu_ctrl_i),
      .res  (base_res),
      .zero (base_zero)
   );

   // Operand classification for the latched M op.
   logic is_div, is_rem, a_neg, b_neg, div_zero, ovf, special;
   logic [XLEN-1:0] mag_a, mag_b_in, special_res;

   assign is_div   = (op_q == ALU_DIV) || (op_q == ALU_DIVU) || (op_q == ALU_REM) || (op_q == ALU_REMU);
   assign is_rem   = (op_q == ALU_REM) || (op_q == ALU_REMU);
   assign a_neg    = opa[XLEN-1] && ((op_q == ALU_MULH) || (op_q == ALU_MULHSU) ||
                                     (op_q == ALU_DIV)  || (op_q == ALU_REM));
   assign b_neg    = opb[XLEN-1] && ((op_q == ALU_MULH) || (op_q == ALU_DIV) || (op_q == ALU_REM));
   assign mag_a    = a_neg ? -opa : opa;
   assign mag_b_in = b_neg ? -opb : opb;
   assign div_zero = is_div && (opb == '0);
   assign ovf      = ((op_q == ALU_DIV) || (op_q == ALU_REM)) && (opa == MIN_INT) && (opb == '1);
   assign special  = div_zero || ovf;
   assign special_res = div_zero ? (is_rem ? opa : '1) : (is_rem ? '0 : MIN_INT);

   // One shift-add or restoring-divide step; PREP seeds it with the fresh magnitudes.
   logic [XLEN-1:0] st_hi, st_lo, st_b, nxt_hi, nxt_lo;
   logic [XLEN:0]   mul_sum, div_sh, div_diff;
   logic            div_ge;

   always_comb begin
      st_hi    = (state == PREP) ? '0       : acc_hi;
      st_lo    = (state == PREP) ? mag_a    : acc_lo;
      st_b     = (state == PREP) ? mag_b_in : mag_b;
      mul_sum  = {1'b0, st_hi} + (st_lo[0] ? {1'b0, st_b} : '0);
      div_sh   = {st_hi, st_lo[XLEN-1]};
      div_ge   = div_sh >= {1'b0, st_b};
      div_diff = div_sh - {1'b0, st_b};
      if (is_div) begin
         nxt_hi = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
         nxt_lo = {st_lo[XLEN-2:0], div_ge};
      end else begin
         nxt_hi = mul_sum[XLEN:1];
         nxt_lo = {mul_sum[0], st_lo[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_res;

   always_comb begin
      prod_s  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quo_s   = neg_res ? -acc_lo : acc_lo;
      rem_s   = neg_res ? -acc_hi : acc_hi;
      fix_res = '0;
      case (op_q)
         ALU_MUL:                        fix_res = prod_s[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:              fix_res = quo_s;
         ALU_REM, ALU_REMU:              fix_res = rem_s;
         default:                        ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = is_md_op(alu_ctrl_i) ? PREP : DONE;
         PREP: state_nxt = special ? DONE : CALC;
         CALC: if (cnt == '0) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: if (ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (kill_i && (state != IDLE)) state_nxt = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         opa     <= '0;
         opb     <= '0;
         op_q    <= '0;
         mag_b   <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         cnt     <= '0;
         neg_res <= 1'b0;
         data_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               opa    <= op1_i;
               opb    <= op2_i;
               op_q   <= alu_ctrl_i;
               cnt    <= CNT_W'(XLEN-1);
               data_q <= is_md_op(alu_ctrl_i) ? '0 : base_res;
               zero_q <= is_md_op(alu_ctrl_i) ? 1'b0 : base_zero;
            end
            PREP: begin
               acc_hi  <= nxt_hi;
               acc_lo  <= nxt_lo;
               mag_b   <= mag_b_in;
               neg_res <= is_rem ? a_neg : (a_neg ^ b_neg);
               cnt     <= cnt - 1'b1;
               if (special) data_q <= special_res;
            end
            CALC: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            FIX:  data_q <= fix_res;
            DONE: if (ready_i) begin
               data_q <= '0;
               zero_q <= 1'b0;
            end
            default: ;
         endcase
         if (kill_i && (state != IDLE)) begin
            data_q <= '0;
            zero_q <= 1'b0;
         end
      end
   end

   assign ready_o = (state == IDLE);
   assign busy_o  = (state != IDLE);
   assign valid_o = (state == DONE);
   assign data_o  = data_q;
   assign zero_o  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_mc : directed self-checking bench for alu_mc (XLEN=32)        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] op1_i = '0;
   logic [31:0] op2_i = '0;
   logic [4:0]  alu_ctrl_i = '0;
   logic        kill_i = 1'b0;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic [31:0] data_o;
   logic        zero_o;
   logic        busy_o;

   int n_cmp = 0;
   int n_err = 0;

   alu_mc #(.XLEN(32), .OP_W(5)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .op1_i      (op1_i),
      .op2_i      (op2_i),
      .alu_ctrl_i (alu_ctrl_i),
      .kill_i     (kill_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .data_o     (data_o),
      .zero_o     (zero_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request, measure latency to valid_o, hold ready_i low for 'hold' cycles.
   task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_d, input logic exp_z,
                        input int exp_lat, input int hold);
      int lat;
      @(negedge clk_i);
      ready_i    = (hold == 0);
      valid_i    = 1'b1;
      alu_ctrl_i = op;
      op1_i      = a;
      op2_i      = b;
      @(negedge clk_i);
      valid_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 60) begin
         @(negedge clk_i);
         lat++;
      end
      check({tag, ".lat"},   64'(lat), 64'(exp_lat));
      check({tag, ".data"},  data_o, exp_d);
      check({tag, ".zero"},  zero_o, exp_z);
      check({tag, ".rdy_o"}, ready_o, 1'b0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_i);
         check($sformatf("%s.hold%0d.valid", tag, i), valid_o, 1'b1);
         check($sformatf("%s.hold%0d.data", tag, i), data_o, exp_d);
      end
      ready_i = 1'b1;
      @(negedge clk_i);
      check({tag, ".post_valid"}, valid_o, 1'b0);
      check({tag, ".post_ready"}, ready_o, 1'b1);
   endtask

   // Start divu 100/7 and stop at the negedge inside cycle 10.
   task automatic start_div_to_cycle10(input string tag);
      @(negedge clk_i);
      valid_i    = 1'b1;
      alu_ctrl_i = ALU_DIVU;
      op1_i      = 32'd100;
      op2_i      = 32'd7;
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (9) @(negedge clk_i);
      check({tag, ".busy_c10"}, busy_o, 1'b1);
   endtask

   task automatic no_valid_for(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk_i);
         if (valid_o) seen = 1'b1;
      end
      check({tag, ".no_valid"}, seen, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      check("rst.ready", ready_o, 1'b1);
      check("rst.valid", valid_o, 1'b0);
      check("rst.data",  data_o, 32'h0);
      check("rst.zero",  zero_o, 1'b0);
      check("rst.busy",  busy_o, 1'b0);
      rst_n_i = 1'b1;

      // base ops
      do_op("add",   ALU_ADD,  32'd7,        32'd5,  32'd12,        1'b0, 1, 0);
      do_op("sub",   ALU_SUB,  32'd5,        32'd7,  32'hFFFFFFFE,  1'b0, 1, 0);
      do_op("xor",   ALU_XOR,  32'h0000F0F0, 32'h0000FFFF, 32'h00000F0F, 1'b0, 1, 0);
      do_op("sra",   ALU_SRA,  32'h80000000, 32'd4,  32'hF8000000,  1'b0, 1, 0);
      do_op("sll",   ALU_SLL,  32'd1,        32'd33, 32'd2,         1'b0, 1, 0);
      do_op("slt",   ALU_SLT,  32'hFFFFFFFF, 32'd1,  32'd1,         1'b0, 1, 0);
      do_op("link",  ALU_LINK, 32'h100,      32'd0,  32'h104,       1'b1, 1, 0);
      do_op("beq",   ALU_BEQ,  32'd3,        32'd3,  32'd0,         1'b1, 1, 0);
      do_op("bltu",  ALU_BLTU, 32'd1,        32'd2,  32'd0,         1'b1, 1, 0);
      do_op("bge",   ALU_BGE,  32'hFFFFFFFF, 32'd0,  32'd0,         1'b0, 1, 0);
      do_op("undef", 5'd26,    32'd5,        32'd6,  32'd0,         1'b0, 1, 0);

      // M ops
      do_op("mulh",   ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34, 0);
      do_op("mul",    ALU_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 34, 0);
      do_op("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 34, 0);
      do_op("div",    ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34, 0);
      do_op("rem",    ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 34, 0);
      do_op("divu",   ALU_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 34, 0);
      do_op("remu",   ALU_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 34, 0);
      do_op("divu0",  ALU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 2, 0);
      do_op("remu0",  ALU_REMU,   32'd9,        32'd0,        32'd9,        1'b0, 2, 0);
      do_op("removf", ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 2, 0);
      do_op("divovf", ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2, 0);
      do_op("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34, 5);

      // kill while idle with a request present: not accepted
      @(negedge clk_i);
      valid_i = 1'b1; kill_i = 1'b1; alu_ctrl_i = ALU_ADD; op1_i = 32'd1; op2_i = 32'd1;
      @(negedge clk_i);
      valid_i = 1'b0; kill_i = 1'b0;
      check("idle_kill.busy",  busy_o, 1'b0);
      check("idle_kill.valid", valid_o, 1'b0);

      // kill mid-divide
      start_div_to_cycle10("kill");
      kill_i = 1'b1;
      @(negedge clk_i);
      kill_i = 1'b0;
      check("kill.busy_c11",  busy_o, 1'b0);
      check("kill.ready_c11", ready_o, 1'b1);
      no_valid_for("kill", 40);
      do_op("kill_add", ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0);

      // asynchronous reset mid-divide
      start_div_to_cycle10("arst");
      rst_n_i = 1'b0;
      #1;
      check("arst.busy",  busy_o, 1'b0);
      check("arst.valid", valid_o, 1'b0);
      check("arst.ready", ready_o, 1'b1);
      check("arst.data",  data_o, 32'h0);
      check("arst.zero",  zero_o, 1'b0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      no_valid_for("arst", 40);
      do_op("arst_add", ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
